// File: rtl/fir_pkg.sv
// Shared widths, limits and sample types for the FIR output path.
package fir_pkg;
  localparam int FIR_OUT_W = 41;
  localparam int SAMPLE_W = 16;
  localparam int SAMPLE_MAX = 32767;
  localparam int SAMPLE_MIN = -32768;

  typedef logic signed [FIR_OUT_W-1:0] fir_acc_t;
  typedef logic signed [SAMPLE_W-1:0] sample_t;
endpackage

// File: rtl/fir_out_decimator_if.sv
// Input stream and output valid/ready handshake of the decimator.
interface fir_out_decimator_if #(
  parameter int IN_W = fir_pkg::FIR_OUT_W,
  parameter int OUT_W = fir_pkg::SAMPLE_W
);
  logic                    in_valid;
  logic signed [IN_W-1:0]  in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output out_valid, out_data
  );
endinterface

// File: rtl/fir_sample_fifo.sv
// Synchronous first-word-fall-through FIFO; push while full is
// accepted only when a pop happens in the same cycle.
module fir_sample_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign count = cnt_q;
  assign rdata = mem_q[rd_q];

  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    if (do_push) begin
      mem_d[wr_q] = wdata;
      wr_d        = wr_q + AW'(1);
    end
    if (do_pop) begin
      rd_d = rd_q + AW'(1);
    end
    cnt_d = cnt_q + (AW+1)'(do_push)
                  - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/fir_out_decimator.sv
// Rounds the full-precision FIR output to a saturated sample,
// decimates it and buffers it behind a valid/ready handshake.
module fir_out_decimator
  import fir_pkg::*;
#(
  parameter int IN_W       = FIR_OUT_W,
  parameter int OUT_W      = SAMPLE_W,
  parameter int SHIFT      = 15,
  parameter int DECIM      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  fir_out_decimator_if.slave  io,
  output logic                sat_flag,
  output logic                drop_flag,
  output logic [7:0]          drop_cnt
);
  localparam int SW    = IN_W + 1;
  localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);

  localparam logic signed [SW-1:0] HALF =
    SW'(1) <<< (SHIFT - 1);
  localparam logic signed [SW-1:0] MAXV =
    SW'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [SW-1:0] MINV =
    -(SW'(2 ** (OUT_W - 1)));

  logic [CNT_W-1:0]        dec_cnt_q, dec_cnt_d;
  logic                    p_valid_q, p_valid_d;
  logic signed [OUT_W-1:0] p_data_q, p_data_d;
  logic                    sat_flag_q, sat_flag_d;
  logic                    drop_flag_q, drop_flag_d;
  logic [7:0]              drop_cnt_q, drop_cnt_d;

  logic signed [SW-1:0]    ext, sum, r;
  logic                    keep, clamp_hi, clamp_lo;
  logic signed [OUT_W-1:0] sat_val;
  logic                    drop, out_valid, pop;

  logic [OUT_W-1:0]        fifo_rdata;
  logic                    fifo_full, fifo_empty;
  logic [AW:0]             fifo_cnt;

  assign out_valid    = (fifo_cnt != '0);
  assign pop          = out_valid && io.out_ready;
  assign io.out_valid = out_valid;
  assign io.out_data  = fifo_empty ? '0 : fifo_rdata;
  assign sat_flag     = sat_flag_q;
  assign drop_flag    = drop_flag_q;
  assign drop_cnt     = drop_cnt_q;

  // Extra headroom bit keeps the rounding add from wrapping.
  always_comb begin
    ext      = SW'(io.in_data);
    sum      = ext + HALF;
    r        = sum >>> SHIFT;
    clamp_hi = (r > MAXV);
    clamp_lo = (r < MINV);
    sat_val  = r[OUT_W-1:0];
    if (clamp_hi) sat_val = MAXV[OUT_W-1:0];
    if (clamp_lo) sat_val = MINV[OUT_W-1:0];
  end

  always_comb begin
    keep      = io.in_valid && (dec_cnt_q == '0);
    dec_cnt_d = dec_cnt_q;
    if (io.in_valid) begin
      dec_cnt_d = (dec_cnt_q == CNT_W'(DECIM - 1))
                ? '0 : dec_cnt_q + CNT_W'(1);
    end
    p_valid_d  = keep;
    p_data_d   = keep ? sat_val : p_data_q;
    sat_flag_d = sat_flag_q |
                 (keep & (clamp_hi | clamp_lo));
    drop        = p_valid_q && fifo_full && !pop;
    drop_flag_d = drop_flag_q | drop;
    drop_cnt_d  = drop_cnt_q;
    if (drop && drop_cnt_q != 8'hFF) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dec_cnt_q   <= '0;
      p_valid_q   <= 1'b0;
      p_data_q    <= '0;
      sat_flag_q  <= 1'b0;
      drop_flag_q <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      dec_cnt_q   <= dec_cnt_d;
      p_valid_q   <= p_valid_d;
      p_data_q    <= p_data_d;
      sat_flag_q  <= sat_flag_d;
      drop_flag_q <= drop_flag_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  fir_sample_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (p_valid_q),
    .wdata (p_data_q),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );
endmodule

// File: tb/tb_fir_out_decimator.sv
// Scoreboard bench: a DECIM=1 and a DECIM=4 instance share
// clock and reset; a forked monitor checks every handshake.
module tb_fir_out_decimator;
  import fir_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fir_out_decimator_if #(
    .IN_W(FIR_OUT_W), .OUT_W(SAMPLE_W)
  ) if1 ();
  fir_out_decimator_if #(
    .IN_W(FIR_OUT_W), .OUT_W(SAMPLE_W)
  ) if4 ();

  logic       sat1, drop1, sat4, drop4;
  logic [7:0] dc1, dc4;

  fir_out_decimator #(
    .DECIM(1), .FIFO_DEPTH(4)
  ) u_d1 (
    .clk(clk), .rst_n(rst_n), .io(if1),
    .sat_flag(sat1), .drop_flag(drop1),
    .drop_cnt(dc1)
  );

  fir_out_decimator #(
    .DECIM(4), .FIFO_DEPTH(4)
  ) u_d4 (
    .clk(clk), .rst_n(rst_n), .io(if4),
    .sat_flag(sat4), .drop_flag(drop4),
    .drop_cnt(dc4)
  );

  int vecs = 0;
  int miss = 0;
  sample_t q1[$];
  sample_t q4[$];

  task automatic chk(string nm, int act, int exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  task automatic mon();
    sample_t e;
    if (if1.out_valid && if1.out_ready) begin
      if (q1.size() == 0) begin
        chk("d1_unexpected", int'(if1.out_data), 99999);
      end else begin
        e = q1.pop_front();
        chk("d1_out", int'(if1.out_data), int'(e));
      end
    end else if (!if1.out_valid) begin
      chk("d1_idle_zero", int'(if1.out_data), 0);
    end
    if (if4.out_valid && if4.out_ready) begin
      if (q4.size() == 0) begin
        chk("d4_unexpected", int'(if4.out_data), 99999);
      end else begin
        e = q4.pop_front();
        chk("d4_out", int'(if4.out_data), int'(e));
      end
    end else if (!if4.out_valid) begin
      chk("d4_idle_zero", int'(if4.out_data), 0);
    end
  endtask

  task automatic send1(longint v);
    if1.in_valid = 1'b1;
    if1.in_data  = FIR_OUT_W'(v);
    @(posedge clk);
    #1 if1.in_valid = 1'b0;
  endtask

  task automatic send4(longint v);
    if4.in_valid = 1'b1;
    if4.in_data  = FIR_OUT_W'(v);
    @(posedge clk);
    #1 if4.in_valid = 1'b0;
  endtask

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    if1.in_valid  = 1'b1;
    if1.in_data   = 41'sd12345;
    if1.out_ready = 1'b1;
    if4.in_valid  = 1'b1;
    if4.in_data   = 41'sd12345;
    if4.out_ready = 1'b1;
    rst_n         = 1'b0;

    fork
      forever begin
        @(negedge clk);
        mon();
      end
    join_none

    // reset held for three edges with valid input
    repeat (3) begin
      @(negedge clk);
      chk("rst_valid", int'(if1.out_valid), 0);
      chk("rst_data", int'(if1.out_data), 0);
      chk("rst_sat", int'(sat1), 0);
      chk("rst_drop", int'(drop1), 0);
      chk("rst_dcnt", int'(dc1), 0);
      chk("rst_valid4", int'(if4.out_valid), 0);
    end
    @(posedge clk);
    #1;
    rst_n        = 1'b1;
    if1.in_valid = 1'b0;
    if4.in_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("post_rst_valid", int'(if1.out_valid), 0);
      chk("post_rst_data", int'(if1.out_data), 0);
    end

    // rounding and 2-cycle latency
    @(posedge clk);
    #1;
    q1.push_back(16'sd4);
    send1(114688);
    @(negedge clk);
    chk("lat1_valid", int'(if1.out_valid), 0);
    @(negedge clk);
    chk("lat2_valid", int'(if1.out_valid), 1);
    chk("lat2_data", int'(if1.out_data), 4);
    @(posedge clk);
    #1;
    q1.push_back(16'sd0);
    send1(-16384);
    q1.push_back(-16'sd1);
    send1(-16385);
    q1.push_back(16'sd0);
    send1(16383);
    cyc(4);
    chk("rnd_drained", q1.size(), 0);
    chk("rnd_sat", int'(sat1), 0);

    // saturation, sticky flag
    q1.push_back(16'sd32767);
    send1(longint'(1) << 31);
    q1.push_back(-16'sd32768);
    send1(-(longint'(1) << 31));
    q1.push_back(16'sd1);
    send1(32768);
    cyc(4);
    chk("sat_sticky", int'(sat1), 1);
    chk("sat_drained", q1.size(), 0);

    // decimation by 4 with an input gap
    q4.push_back(16'sd0);
    q4.push_back(16'sd4);
    q4.push_back(16'sd8);
    for (int k = 0; k < 12; k++) begin
      send4(longint'(k) <<< 15);
      if (k == 5) cyc(3);
    end
    cyc(6);
    chk("dec_drained", q4.size(), 0);
    chk("dec_sat4", int'(sat4), 0);

    // backpressure and overflow drops
    chk("bp_drop_pre", int'(drop1), 0);
    if1.out_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      if (k <= 4) q1.push_back(sample_t'(k));
      send1(longint'(k) <<< 15);
    end
    cyc(2);
    chk("bp_drop_flag", int'(drop1), 1);
    chk("bp_drop_cnt", int'(dc1), 2);
    chk("bp_valid", int'(if1.out_valid), 1);
    chk("bp_head", int'(if1.out_data), 1);
    @(negedge clk);
    chk("bp_hold", int'(if1.out_data), 1);
    @(posedge clk);
    #1 if1.out_ready = 1'b1;
    cyc(6);
    chk("bp_empty", int'(if1.out_valid), 0);
    chk("bp_drained", q1.size(), 0);

    // full with simultaneous pop accepts the write
    if1.out_ready = 1'b0;
    for (int k = 11; k <= 14; k++) begin
      q1.push_back(sample_t'(k));
      send1(longint'(k) <<< 15);
    end
    q1.push_back(16'sd15);
    send1(longint'(15) <<< 15);
    if1.out_ready = 1'b1;
    @(posedge clk);
    #1 if1.out_ready = 1'b0;
    cyc(1);
    chk("fp_drop_cnt", int'(dc1), 2);
    chk("fp_valid", int'(if1.out_valid), 1);
    chk("fp_head", int'(if1.out_data), 12);
    if1.out_ready = 1'b1;
    cyc(2);
    if1.out_ready = 1'b0;
    chk("fp_left", q1.size(), 2);

    // mid-operation reset discards the FIFO contents
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    q1.delete();
    @(negedge clk);
    chk("mrst_valid", int'(if1.out_valid), 0);
    chk("mrst_dcnt", int'(dc1), 0);
    chk("mrst_drop", int'(drop1), 0);
    chk("mrst_sat", int'(sat1), 0);
    @(posedge clk);
    #1 if1.out_ready = 1'b1;
    q1.push_back(16'sd7);
    send1(longint'(7) <<< 15);
    cyc(4);
    chk("after_rst_drained", q1.size(), 0);
    chk("final_q4", q4.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, miss);
    $finish;
  end
endmodule

// File: doc/fir_out_decimator.md
Name: fir_out_decimator

Overview:
Downstream stage of digital_filter_15_tap_lowpass. Consumes the filter's 41-bit signed full-precision output and rounds it back to a 16-bit signed sample, with saturation. Decimates by an integer factor and buffers the result in a small FIFO behind a valid/ready output handshake. Overflow and drop conditions are reported as sticky status.

Parameters:
IN_W, 41, width of the signed filter output consumed
OUT_W, 16, width of the signed output sample
SHIFT, 15, arithmetic right shift applied after rounding; matches Q15 coefficients
DECIM, 4, decimation factor (1 = no decimation); legal range 1..256
FIFO_DEPTH, 4, output buffer depth in samples; power of two, at least 2

Ports:
clk  in  1  single clock, same domain as the FIR
rst_n  in  1  synchronous active-low reset, sampled on rising clk
in_valid  in  1  in_data valid this cycle; tied high at the FIR boundary
in_data  in  IN_W  signed filter output (filtered_signal)
out_valid  out  1  out_data holds a valid sample
out_ready  in  1  consumer accepts the sample when high together with out_valid
out_data  out  OUT_W  signed rounded, saturated, decimated sample
sat_flag  out  1  sticky; set when any accepted sample saturated
drop_flag  out  1  sticky; set when any sample was dropped because the FIFO was full
drop_cnt  out  8  count of dropped samples; saturates at 255

Behaviour:
- Reset: when rst_n is low at a rising edge, all state clears together:
  - FIFO emptied; its contents are discarded even mid-operation.
  - Pipeline register invalid; dec_cnt = 0.
  - Outputs: out_valid = 0, out_data = 0, sat_flag = 0, drop_flag = 0, drop_cnt = 0.
- Decimation:
  - dec_cnt advances by 1 on each in_valid and wraps from DECIM-1 to 0.
  - A sample is kept only when in_valid is high and dec_cnt == 0, so the first sample after reset is kept.
  - In_valid low holds dec_cnt.
- Arithmetic, on kept samples:
  - Compute r = (in_data + 2^(SHIFT-1)) >>> SHIFT. The add is done in IN_W+1 bits so it cannot overflow. This is round-half-up toward +inf.
  - If r > 2^(OUT_W-1)-1, clamp to 32767. If r < -2^(OUT_W-1), clamp to -32768. Either clamp sets sat_flag.
- Pipeline:
  - The rounded, saturated value is registered into p_data/p_valid on the edge that accepts the sample, cycle t.
  - The FIFO write happens on the next edge.
  - out_valid is high in cycle t+2 if the FIFO was empty. Fixed latency is 2 cycles.
- FIFO and handshake:
  - First-word-fall-through.
  - out_data is 0 whenever out_valid = 0.
  - While out_valid && !out_ready, out_data and out_valid hold stable.
  - A pop occurs when out_valid && out_ready.
  - Samples are delivered in order.
- Full boundary:
  - If p_valid, the FIFO is full and no pop occurs this cycle, the sample is dropped. drop_flag sets and drop_cnt increments, saturating at 255.
  - If full and a pop occurs in the same cycle, the write is accepted and nothing is dropped.
- Empty boundary: a pop is never possible while empty. A write to an empty FIFO appears on out_valid in the following cycle.
- Sticky flags clear only on reset.

Decomposition:
- Package fir_pkg holds:
  - Constants FIR_OUT_W = 41, SAMPLE_W = 16, SAMPLE_MAX = 32767, SAMPLE_MIN = -32768.
  - Typedefs fir_acc_t (logic signed [40:0]) and sample_t (logic signed [15:0]).
- One sub-module: fir_sample_fifo, a synchronous FWFT FIFO.
  - Parameters: WIDTH, DEPTH.
  - Ports: push/pop/full/empty, count in log2(DEPTH)+1 bits.
  - Uses the same clk/rst_n.
- Decimation, rounding, saturation and drop logic live in fir_out_decimator.

Test Plan:
1. Reset: hold rst_n = 0 for 3 cycles with in_valid = 1 and in_data = 12345 -> out_valid = 0, out_data = 0, all flags 0, drop_cnt = 0 during reset and for 2 cycles after release.
2. Rounding, DECIM = 1, out_ready = 1: in_data = 114688 -> out_data = 4 exactly 2 cycles later; -16384 -> 0; -16385 -> -1; 16383 -> 0.
3. Saturation: in_data = 2^31 -> out_data = 32767, sat_flag = 1; then -2^31 -> -32768. sat_flag stays 1 after later in-range samples.
4. Decimation, DECIM = 4: continuous in_valid with in_data = k*2^15 for k = 0..11 -> out_data sequence 0, 4, 8 only. Gap in_valid low for 3 cycles after k = 5 -> next output is k = 8.
5. Backpressure, DECIM = 1, FIFO_DEPTH = 4:
   - Stimulus: out_ready = 0 with samples 1..6 (x2^15).
   - Response: samples 5 and 6 dropped, drop_flag = 1, drop_cnt = 2.
   - Then raise out_ready = 1 -> outputs 1, 2, 3, 4 in order, then out_valid = 0.
6. Full with simultaneous pop: FIFO full, out_ready pulses for 1 cycle while a new sample reaches the write stage -> sample accepted, drop_cnt unchanged. Mid-operation rst_n pulse -> FIFO empty, out_valid = 0 the next cycle.
